wdt_kick_gen: RTL and testbench
===============================

Name: wdt_kick_gen

Overview:
- Kick-side partner of the watchdog timer (WDT_top).
- Monitors an application heartbeat and drives kick words onto the watchdog's `data_in` bus, but only while the application proves alive.
- Services the watchdog interrupt: it withholds kicks, waits a recovery window, and then requests a system reset.
- Sits between application logic and WDT_top; its `data_out` connects directly to WDT_top `data_in`.

Parameters:
- DATA_WIDTH, 32, width of the kick bus (matches WDT_top).
- KICK_PERIOD, 8, cycles spent in WAIT before a kick decision (>=2).
- KICK_WORD, 32'hA, word driven during a kick.
- IDLE_WORD, 32'h0, word driven when not kicking.
- RECOVER_CYCLES, 16, cycles the interrupt may remain high before a reset request (>=2).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous active-high reset.
- enable  in  1  block enable; low forces IDLE.
- app_alive  in  1  one-or-more-cycle heartbeat from monitored logic.
- wdt_interrupt  in  1  interrupt from WDT_top (`interrupt_top`).
- data_out  out  DATA_WIDTH  kick bus to WDT_top `data_in`.
- data_valid  out  1  high on cycles where data_out carries a kick word.
- kick_count  out  8  saturating count of kicks issued.
- recover_req  out  1  one-cycle system reset request.
- fault  out  1  high while in FAULT.

Behaviour:
- Reset (rst sampled high): state=IDLE, cnt=0, rec_cnt=0, alive_seen=0, kick_count=0, data_out=IDLE_WORD, data_valid=0, recover_req=0, fault=0.
- All outputs are Moore, decoded from registered state; kick_count is a register.
- Priority per edge: rst > !enable (go to IDLE, clear cnt/rec_cnt/alive_seen) > wdt_interrupt > normal transitions.

States:
- IDLE:
  - Outputs idle.
  - enable=1 -> WAIT with cnt=0, alive_seen=0.
- WAIT:
  - cnt increments each cycle.
  - app_alive=1 on any WAIT cycle sets alive_seen, including the terminal cycle cnt==KICK_PERIOD-1.
  - At cnt==KICK_PERIOD-1: alive_seen (or app_alive this cycle) -> KICK; else -> HOLD.
- KICK:
  - Exactly 1 cycle: data_out=KICK_WORD, data_valid=1.
  - kick_count+1, saturating at 255.
  - Next state WAIT with cnt=0, alive_seen=0.
  - app_alive during KICK is not recorded.
- HOLD:
  - Kicks withheld; data_out=IDLE_WORD.
  - app_alive=1 -> KICK next cycle.
- RECOVER:
  - Entered from WAIT/KICK/HOLD when wdt_interrupt=1, with rec_cnt=0. A KICK pre-empted by the interrupt is not issued and does not count.
  - rec_cnt increments.
  - wdt_interrupt=0 -> WAIT with cnt=0, alive_seen=0.
  - rec_cnt==RECOVER_CYCLES-1 with interrupt still high -> FAULT.
- FAULT:
  - fault=1.
  - recover_req=1 on the first FAULT cycle only.
  - Stays in FAULT regardless of interrupt or app_alive; exits only via rst or enable=0 (-> IDLE).

Timing and boundaries:
- Timing: enable sampled at edge e gives WAIT on cycles e+1..e+KICK_PERIOD and KICK at e+KICK_PERIOD+1. The steady kick interval is KICK_PERIOD+1 cycles.
- Simultaneous wdt_interrupt and the terminal WAIT cycle: RECOVER wins and no kick is issued.
- enable dropped mid-RECOVER: IDLE, with no recover_req.
- rst mid-KICK: the kick is aborted and kick_count is cleared.
- kick_count saturates at 255 and does not wrap.

Optional Feature:
- Macro: WDT_KICK_SEQ_EN.
- Defined:
  - KICK becomes a 2-cycle unlock sequence: cycle 1 drives KICK_WORD, cycle 2 drives KICK_WORD2 (extra parameter, default 32'hC). data_valid is high on both cycles.
  - kick_count increments once per sequence, on the second cycle.
  - wdt_interrupt on cycle 1 aborts to RECOVER; the partial sequence is not counted.
  - Steady kick interval becomes KICK_PERIOD+2.
- Undefined: single-cycle KICK as above; KICK_WORD2 parameter absent.

Test Plan:
- Reset then enable=1 with app_alive pulsed once per period (KICK_PERIOD=8) -> first data_out=32'hA / data_valid=1 exactly 9 cycles after enable; repeats every 9 cycles; kick_count=3 after 3 periods.
- No app_alive for 20 cycles -> one HOLD entry, no data_valid, data_out stays 32'h0; then pulse app_alive -> kick on the next cycle, kick_count+1.
- wdt_interrupt asserted during WAIT, deasserted after 5 cycles -> RECOVER, no recover_req; returns to WAIT and the next kick occurs 9 cycles after deassertion (given app_alive).
- wdt_interrupt held 16+ cycles -> recover_req single pulse on the 17th cycle after RECOVER entry; fault=1 held until enable=0, then fault=0 and IDLE.
- 300 kicks -> kick_count=255 saturated. rst asserted on a KICK cycle -> next cycle all outputs at reset values.
- With WDT_KICK_SEQ_EN: alive each period -> data_out sequence 32'hA, 32'hC on consecutive cycles, data_valid high on both, kick_count+1 per pair. Interrupt on the 32'hA cycle -> no 32'hC, and no count.

Source files
------------

// File: rtl/wdt_kick_gen.sv
// wdt_kick_gen: heartbeat-gated kick generator and interrupt service partner for WDT_top.
// Define WDT_KICK_SEQ_EN to turn each kick into a two-word unlock sequence (KICK_WORD, KICK_WORD2).
module wdt_kick_gen #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    KICK_PERIOD    = 8,
  parameter logic [DATA_WIDTH-1:0] KICK_WORD      = 'hA,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD      = '0,
  parameter int                    RECOVER_CYCLES = 16
`ifdef WDT_KICK_SEQ_EN
  , parameter logic [DATA_WIDTH-1:0] KICK_WORD2   = 'hC
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  app_alive,
  input  logic                  wdt_interrupt,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [7:0]            kick_count,
  output logic                  recover_req,
  output logic                  fault
);

  localparam int CNT_W = (KICK_PERIOD > 1) ? $clog2(KICK_PERIOD) : 1;
  localparam int REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KICK_PERIOD - 1);
  localparam logic [REC_W-1:0] REC_LAST = REC_W'(RECOVER_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_KICK,
    S_HOLD,
    S_RECOVER,
    S_FAULT
`ifdef WDT_KICK_SEQ_EN
    , S_KICK2
`endif
  } state_e;

  // The kick is counted when the state that completes it is entered.
`ifdef WDT_KICK_SEQ_EN
  localparam state_e COUNT_STATE = S_KICK2;
`else
  localparam state_e COUNT_STATE = S_KICK;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REC_W-1:0] rec_cnt_q, rec_cnt_d;
  logic             alive_seen_q, alive_seen_d;
  logic [7:0]       kick_count_q;
  logic             recover_req_q;
  logic             in_service;

  always_comb begin
    in_service = (state_q == S_WAIT) || (state_q == S_KICK) || (state_q == S_HOLD);
`ifdef WDT_KICK_SEQ_EN
    in_service = in_service || (state_q == S_KICK2);
`endif
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rec_cnt_d    = rec_cnt_q;
    alive_seen_d = alive_seen_q;
    if (!enable) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      rec_cnt_d    = '0;
      alive_seen_d = 1'b0;
    end else if (wdt_interrupt && in_service) begin
      state_d      = S_RECOVER;
      cnt_d        = '0;
      rec_cnt_d    = '0;
      alive_seen_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d      = S_WAIT;
          cnt_d        = '0;
          alive_seen_d = 1'b0;
        end
        S_WAIT: begin
          if (cnt_q == CNT_LAST) begin
            state_d      = (alive_seen_q || app_alive) ? S_KICK : S_HOLD;
            cnt_d        = '0;
            alive_seen_d = 1'b0;
          end else begin
            cnt_d        = cnt_q + 1'b1;
            alive_seen_d = alive_seen_q || app_alive;
          end
        end
        S_KICK: begin
`ifdef WDT_KICK_SEQ_EN
          state_d      = S_KICK2;
`else
          state_d      = S_WAIT;
`endif
          cnt_d        = '0;
          alive_seen_d = 1'b0;
        end
`ifdef WDT_KICK_SEQ_EN
        S_KICK2: begin
          state_d      = S_WAIT;
          cnt_d        = '0;
          alive_seen_d = 1'b0;
        end
`endif
        S_HOLD: begin
          if (app_alive) state_d = S_KICK;
        end
        S_RECOVER: begin
          if (!wdt_interrupt) begin
            state_d      = S_WAIT;
            cnt_d        = '0;
            alive_seen_d = 1'b0;
          end else if (rec_cnt_q == REC_LAST) begin
            state_d = S_FAULT;
          end else begin
            rec_cnt_d = rec_cnt_q + 1'b1;
          end
        end
        S_FAULT: state_d = S_FAULT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rec_cnt_q     <= '0;
      alive_seen_q  <= 1'b0;
      kick_count_q  <= 8'd0;
      recover_req_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rec_cnt_q     <= rec_cnt_d;
      alive_seen_q  <= alive_seen_d;
      recover_req_q <= (state_d == S_FAULT) && (state_q != S_FAULT);
      if ((state_d == COUNT_STATE) && (state_q != COUNT_STATE) && (kick_count_q != 8'hFF))
        kick_count_q <= kick_count_q + 8'd1;
    end
  end

  always_comb begin
    data_out   = IDLE_WORD;
    data_valid = 1'b0;
    case (state_q)
      S_KICK: begin
        data_out   = KICK_WORD;
        data_valid = 1'b1;
      end
`ifdef WDT_KICK_SEQ_EN
      S_KICK2: begin
        data_out   = KICK_WORD2;
        data_valid = 1'b1;
      end
`endif
      default: begin
        data_out   = IDLE_WORD;
        data_valid = 1'b0;
      end
    endcase
  end

  assign fault       = (state_q == S_FAULT);
  assign recover_req = recover_req_q;
  assign kick_count  = kick_count_q;

endmodule

// File: tb/tb_wdt_kick_gen.sv
// Self-checking bench for wdt_kick_gen: vector table, directed corner sequences, randomized run vs. model.
module tb_wdt_kick_gen;

  localparam int KP = 8;
  localparam int RC = 16;
`ifdef WDT_KICK_SEQ_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif
  localparam int KICK_LEN = SEQ ? 2 : 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        app_alive = 1'b0;
  logic        wdt_interrupt = 1'b0;
  logic [31:0] data_out;
  logic        data_valid;
  logic [7:0]  kick_count;
  logic        recover_req;
  logic        fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wdt_kick_gen dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .app_alive     (app_alive),
    .wdt_interrupt (wdt_interrupt),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .kick_count    (kick_count),
    .recover_req   (recover_req),
    .fault         (fault)
  );

  typedef struct {
    logic        r, e, a, i;
    logic        v;
    logic [31:0] d;
    logic [7:0]  kc;
    logic        req, flt;
  } vec_t;

  vec_t vecs[16];

  task automatic applyStimulus(input logic r, input logic e, input logic a, input logic i);
    rst = r; enable = e; app_alive = a; wdt_interrupt = i;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setVec(input int k, input logic r, input logic e, input logic a, input logic i,
                        input logic v, input logic [31:0] d, input logic [7:0] kc,
                        input logic req, input logic flt);
    vecs[k].r = r; vecs[k].e = e; vecs[k].a = a; vecs[k].i = i;
    vecs[k].v = v; vecs[k].d = d; vecs[k].kc = kc; vecs[k].req = req; vecs[k].flt = flt;
  endtask

  // Higher-level reference: ages of the current activity rather than a state register.
  bit mActive, mHeard, mHolding;
  int mWaitAge, mKickPhase, mRecAge, mFaultAge, mKicks;

  task automatic modelClear();
    mActive = 0; mWaitAge = -1; mHeard = 0; mKickPhase = 0;
    mHolding = 0; mRecAge = -1; mFaultAge = -1;
  endtask

  task automatic modelStartWindow();
    mWaitAge = 0; mHeard = 0; mKickPhase = 0; mHolding = 0; mRecAge = -1;
  endtask

  task automatic modelIssueKick();
    mKickPhase = 1; mWaitAge = -1; mHolding = 0;
    if (!SEQ && mKicks < 255) mKicks++;
  endtask

  task automatic modelStep(input logic r, input logic e, input logic a, input logic i);
    if (r) begin
      modelClear();
      mKicks = 0;
    end else if (!e) begin
      modelClear();
    end else if (!mActive) begin
      mActive = 1;
      modelStartWindow();
    end else if (mFaultAge >= 0) begin
      mFaultAge++;
    end else if (mRecAge >= 0) begin
      if (!i) modelStartWindow();
      else if (mRecAge == RC - 1) begin
        mRecAge = -1;
        mFaultAge = 0;
      end else mRecAge++;
    end else if (i) begin
      mWaitAge = -1; mHeard = 0; mKickPhase = 0; mHolding = 0; mRecAge = 0;
    end else if (mKickPhase == 1) begin
      if (SEQ) begin
        mKickPhase = 2;
        if (mKicks < 255) mKicks++;
      end else modelStartWindow();
    end else if (mKickPhase == 2) begin
      modelStartWindow();
    end else if (mHolding) begin
      if (a) modelIssueKick();
    end else begin
      if (a) mHeard = 1;
      if (mWaitAge == KP - 1) begin
        if (mHeard) modelIssueKick();
        else begin
          mHolding = 1;
          mWaitAge = -1;
        end
      end else mWaitAge++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int bad, kickAt, kicks, wraps;
    logic [7:0] prevKc;
    logic reqSeen, faultSeen, kickFound, irqHigh;
    logic r, e, a, i;

    // Vector table: reset, first kick after enable, post-kick, IDLE/RECOVER transitions.
    setVec(0, 1, 0, 0, 0, 0, 32'h0, 8'd0, 0, 0);
    setVec(1, 0, 1, 0, 0, 0, 32'h0, 8'd0, 0, 0);
    for (int k = 2; k <= 8; k++) setVec(k, 0, 1, (k == 4), 0, 0, 32'h0, 8'd0, 0, 0);
    setVec(9, 0, 1, 0, 0, 1, 32'hA, SEQ ? 8'd0 : 8'd1, 0, 0);
    setVec(10, 0, 1, 0, 0, SEQ, SEQ ? 32'hC : 32'h0, 8'd1, 0, 0);
    setVec(11, 1, 1, 0, 0, 0, 32'h0, 8'd0, 0, 0);
    setVec(12, 0, 1, 0, 1, 0, 32'h0, 8'd0, 0, 0);
    setVec(13, 0, 1, 0, 1, 0, 32'h0, 8'd0, 0, 0);
    setVec(14, 0, 1, 0, 0, 0, 32'h0, 8'd0, 0, 0);
    setVec(15, 0, 0, 0, 0, 0, 32'h0, 8'd0, 0, 0);

    for (int k = 0; k < 16; k++) begin
      applyStimulus(vecs[k].r, vecs[k].e, vecs[k].a, vecs[k].i);
      checkOutput($sformatf("vec%0d.valid", k), 32'(data_valid), 32'(vecs[k].v));
      checkOutput($sformatf("vec%0d.data", k), data_out, vecs[k].d);
      checkOutput($sformatf("vec%0d.kick_count", k), 32'(kick_count), 32'(vecs[k].kc));
      checkOutput($sformatf("vec%0d.recover_req", k), 32'(recover_req), 32'(vecs[k].req));
      checkOutput($sformatf("vec%0d.fault", k), 32'(fault), 32'(vecs[k].flt));
    end

    // No heartbeat: HOLD keeps the bus quiet, then one pulse releases a kick.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      applyStimulus(0, 1, 0, 0);
      if (data_valid !== 1'b0 || data_out !== 32'h0) bad++;
    end
    checkOutput("hold_quiet_cycles", 32'(bad), 32'd0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("hold_release_valid", 32'(data_valid), 32'd1);
    checkOutput("hold_release_data", data_out, 32'hA);
`ifdef WDT_KICK_SEQ_EN
    applyStimulus(0, 1, 0, 0);
    checkOutput("hold_release_word2", data_out, 32'hC);
`endif
    checkOutput("hold_release_count", 32'(kick_count), 32'd1);

    // Interrupt held: recover_req on the 17th interrupt edge, fault until enable drops.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    for (int n = 0; n < 3; n++) applyStimulus(0, 1, 0, 0);
    reqSeen = 1'b0; faultSeen = 1'b0;
    for (int n = 1; n <= RC; n++) begin
      applyStimulus(0, 1, 0, 1);
      reqSeen = reqSeen | recover_req;
      faultSeen = faultSeen | fault;
    end
    checkOutput("recover_no_early_req", 32'(reqSeen), 32'd0);
    checkOutput("recover_no_early_fault", 32'(faultSeen), 32'd0);
    applyStimulus(0, 1, 0, 1);
    checkOutput("fault_entry_req", 32'(recover_req), 32'd1);
    checkOutput("fault_entry_fault", 32'(fault), 32'd1);
    applyStimulus(0, 1, 1, 0);
    checkOutput("fault_req_one_cycle", 32'(recover_req), 32'd0);
    checkOutput("fault_sticky", 32'(fault), 32'd1);
    checkOutput("fault_no_kick", 32'(data_valid), 32'd0);
    applyStimulus(0, 0, 0, 0);
    checkOutput("fault_cleared_by_disable", 32'(fault), 32'd0);

    // Enable dropped mid-RECOVER: IDLE with no reset request.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    for (int n = 0; n < 5; n++) applyStimulus(0, 1, 0, 1);
    reqSeen = 1'b0; faultSeen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      applyStimulus(0, 0, 0, 1);
      reqSeen = reqSeen | recover_req;
      faultSeen = faultSeen | fault;
    end
    checkOutput("disable_in_recover_req", 32'(reqSeen), 32'd0);
    checkOutput("disable_in_recover_fault", 32'(faultSeen), 32'd0);

    // Short interrupt: kick lands KP+1 edges after the deasserting edge.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0);
    for (int n = 0; n < 5; n++) applyStimulus(0, 1, 1, 1);
    kickAt = -1;
    for (int n = 1; n <= 30; n++) begin
      applyStimulus(0, 1, 1, 0);
      if (data_valid === 1'b1) begin
        kickAt = n;
        break;
      end
    end
    checkOutput("recover_return_latency", 32'(kickAt), 32'(KP + 1));

    // Interrupt coincides with the terminal WAIT cycle: no kick, no count.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    for (int n = 0; n < KP - 1; n++) applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 1);
    checkOutput("terminal_irq_no_valid", 32'(data_valid), 32'd0);
    checkOutput("terminal_irq_no_count", 32'(kick_count), 32'd0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("terminal_irq_after", 32'(data_valid), 32'd0);

`ifdef WDT_KICK_SEQ_EN
    // Interrupt on the first word of the sequence: second word suppressed, not counted.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    for (int n = 0; n < KP; n++) applyStimulus(0, 1, 1, 0);
    checkOutput("seq_first_word", data_out, 32'hA);
    applyStimulus(0, 1, 1, 1);
    checkOutput("seq_abort_no_word2", data_out, 32'h0);
    checkOutput("seq_abort_no_valid", 32'(data_valid), 32'd0);
    checkOutput("seq_abort_no_count", 32'(kick_count), 32'd0);
`endif

    // Reset on a KICK cycle aborts it and clears the count.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    kickFound = 1'b0;
    for (int n = 0; n < 30; n++) begin
      applyStimulus(0, 1, 1, 0);
      if (data_valid === 1'b1) begin
        kickFound = 1'b1;
        break;
      end
    end
    checkOutput("rst_kick_found", 32'(kickFound), 32'd1);
    applyStimulus(1, 1, 1, 0);
    checkOutput("rst_kick_valid", 32'(data_valid), 32'd0);
    checkOutput("rst_kick_data", data_out, 32'h0);
    checkOutput("rst_kick_count", 32'(kick_count), 32'd0);
    checkOutput("rst_kick_fault", 32'(fault), 32'd0);

    // Saturation: well over 255 kicks with a constant heartbeat.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0);
    kicks = 0; wraps = 0; prevKc = kick_count;
    for (int n = 0; n < 300 * (KP + KICK_LEN) + KP + 5; n++) begin
      applyStimulus(0, 1, 1, 0);
      if (data_valid === 1'b1 && data_out === 32'hA) kicks++;
      if (kick_count < prevKc) wraps++;
      prevKc = kick_count;
    end
    checkOutput("sat_kicks_issued", 32'(kicks >= 300), 32'd1);
    checkOutput("sat_count", 32'(kick_count), 32'd255);
    checkOutput("sat_no_wrap", 32'(wraps), 32'd0);

    // Randomized run against the reference model.
    applyStimulus(1, 0, 0, 0);
    modelClear();
    mKicks = 0;
    irqHigh = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 59) != 0);
      a = ($urandom_range(0, 5) == 0);
      if (irqHigh) irqHigh = ($urandom_range(0, 13) != 0);
      else irqHigh = ($urandom_range(0, 39) == 0);
      i = irqHigh;
      applyStimulus(r, e, a, i);
      modelStep(r, e, a, i);
      checkOutput($sformatf("rand%0d.valid", n), 32'(data_valid), 32'(mKickPhase != 0));
      checkOutput($sformatf("rand%0d.data", n), data_out,
                  (mKickPhase == 1) ? 32'hA : (mKickPhase == 2) ? 32'hC : 32'h0);
      checkOutput($sformatf("rand%0d.kick_count", n), 32'(kick_count), 32'(mKicks));
      checkOutput($sformatf("rand%0d.recover_req", n), 32'(recover_req), 32'(mFaultAge == 0));
      checkOutput($sformatf("rand%0d.fault", n), 32'(fault), 32'(mFaultAge >= 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
